// File: rtl/mp_chunked_resolver.sv
// Resolves a redundant (sum, carry) multi-precision word into binary with one
// time-multiplexed CHUNK-bit adder, optionally followed by one conditional subtraction of M.
module mp_chunked_resolver #(
    parameter int WIDTH = 512,
    parameter int CHUNK = 128
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             reduce,
    input  logic [WIDTH+1:0] sum_in,
    input  logic [WIDTH+1:0] carry_in,
    input  logic [WIDTH-1:0] modulus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] result,
    output logic             reduced
);

    localparam int W2  = WIDTH + 2;
    localparam int NCH = (W2 + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [PW-1:0] W2_MASK = ~({PW{1'b1}} << W2);

    typedef enum logic [1:0] {IDLE, ADD, SUB, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   chunkIdx_q;
    logic            carry_q;
    logic            reduce_q;
    logic [PW-1:0]   sumShift_q;
    logic [PW-1:0]   carryShift_q;
    logic [PW-1:0]   modShift_q;
    logic [PW-1:0]   xWord_q;
    logic [W2-1:0]   result_q;
    logic            reduced_q;
    logic            outValid_q;

    logic [PW-1:0]   sumPad;
    logic [PW-1:0]   carryPad;
    logic [PW-1:0]   modPad;
    logic [CHUNK-1:0] opA;
    logic [CHUNK-1:0] opB;
    logic [CHUNK:0]  addFull;
    logic [PW-1:0]   sliceTop;
    logic [PW-1:0]   xLowTop;
    logic [PW-1:0]   xAdd_d;
    logic [PW-1:0]   xRot_d;
    logic [PW-1:0]   dWord_d;
    logic            lastChunk;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign reduced   = reduced_q;
    assign lastChunk = (chunkIdx_q == CW'(NCH - 1));

    // Operands live in shift registers so the adder always reads chunk 0; results enter at the top.
    always_comb begin
        sumPad              = '0;
        sumPad[W2-1:0]      = sum_in;
        carryPad            = '0;
        carryPad[W2-1:0]    = carry_in;
        modPad              = '0;
        modPad[WIDTH-1:0]   = modulus;

        opA = (state_q == SUB) ? xWord_q[CHUNK-1:0]     : sumShift_q[CHUNK-1:0];
        opB = (state_q == SUB) ? ~modShift_q[CHUNK-1:0] : carryShift_q[CHUNK-1:0];
        addFull = {1'b0, opA} + {1'b0, opB} + {{CHUNK{1'b0}}, carry_q};

        sliceTop                  = '0;
        sliceTop[PW-1 -: CHUNK]   = addFull[CHUNK-1:0];
        xLowTop                   = '0;
        xLowTop[PW-1 -: CHUNK]    = xWord_q[CHUNK-1:0];
        xAdd_d  = (xWord_q >> CHUNK) | sliceTop;
        xRot_d  = (xWord_q >> CHUNK) | xLowTop;
        dWord_d = (sumShift_q >> CHUNK) | sliceTop;
    end

    // During SUB carry_q holds the inverted borrow, so it starts at 1 (no borrow).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            chunkIdx_q   <= '0;
            carry_q      <= 1'b0;
            reduce_q     <= 1'b0;
            sumShift_q   <= '0;
            carryShift_q <= '0;
            modShift_q   <= '0;
            xWord_q      <= '0;
            result_q     <= '0;
            reduced_q    <= 1'b0;
            outValid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sumShift_q   <= sumPad;
                        carryShift_q <= carryPad;
                        modShift_q   <= modPad;
                        reduce_q     <= reduce;
                        chunkIdx_q   <= '0;
                        carry_q      <= 1'b0;
                        state_q      <= ADD;
                    end
                end
                ADD: begin
                    sumShift_q   <= sumShift_q >> CHUNK;
                    carryShift_q <= carryShift_q >> CHUNK;
                    carry_q      <= addFull[CHUNK];
                    if (lastChunk) begin
                        xWord_q    <= xAdd_d & W2_MASK;
                        chunkIdx_q <= '0;
                        if (reduce_q) begin
                            carry_q <= 1'b1;
                            state_q <= SUB;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        xWord_q    <= xAdd_d;
                        chunkIdx_q <= chunkIdx_q + 1'b1;
                    end
                end
                SUB: begin
                    xWord_q    <= xRot_d;
                    sumShift_q <= dWord_d;
                    modShift_q <= modShift_q >> CHUNK;
                    carry_q    <= addFull[CHUNK];
                    if (lastChunk) begin
                        chunkIdx_q <= '0;
                        state_q    <= DONE;
                    end else begin
                        chunkIdx_q <= chunkIdx_q + 1'b1;
                    end
                end
                DONE: begin
                    // First DONE cycle loads the result register; it is then held until accepted.
                    if (!outValid_q) begin
                        result_q   <= (reduce_q && carry_q) ? sumShift_q[W2-1:0] : xWord_q[W2-1:0];
                        reduced_q  <= reduce_q && carry_q;
                        outValid_q <= 1'b1;
                    end else if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_chunked_resolver.sv
// Directed and randomized checks of mp_chunked_resolver with CHUNK=128 (NCH=5)
// and a second instance with CHUNK=100 (NCH=6, partial last chunk).
module tb_mp_chunked_resolver;

   localparam int WIDTH = 512;
   localparam int W2    = WIDTH + 2;

   logic clk = 1'b0;
   logic resetn;

   logic             inValidA, inReadyA, reduceA, outValidA, outReadyA, reducedA;
   logic [W2-1:0]    sumA, carryA, resultA;
   logic [WIDTH-1:0] modA;

   logic             inValidB, inReadyB, reduceB, outValidB, outReadyB, reducedB;
   logic [W2-1:0]    sumB, carryB, resultB;
   logic [WIDTH-1:0] modB;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mp_chunked_resolver #(.WIDTH(WIDTH), .CHUNK(128)) dutA (
      .clk(clk), .resetn(resetn),
      .in_valid(inValidA), .in_ready(inReadyA), .reduce(reduceA),
      .sum_in(sumA), .carry_in(carryA), .modulus(modA),
      .out_valid(outValidA), .out_ready(outReadyA),
      .result(resultA), .reduced(reducedA)
   );

   mp_chunked_resolver #(.WIDTH(WIDTH), .CHUNK(100)) dutB (
      .clk(clk), .resetn(resetn),
      .in_valid(inValidB), .in_ready(inReadyB), .reduce(reduceB),
      .sum_in(sumB), .carry_in(carryB), .modulus(modB),
      .out_valid(outValidB), .out_ready(outReadyB),
      .result(resultB), .reduced(reducedB)
   );

   function automatic logic [W2-1:0] rnd514();
      logic [543:0] t;
      for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
      return t[W2-1:0];
   endfunction

   // One operation through the selected instance with out_ready held high; inputs are
   // scrambled right after acceptance to show they are not re-read.
   task automatic applyStimulus(input bit sel, input logic [W2-1:0] s, input logic [W2-1:0] c,
                                input logic [WIDTH-1:0] m, input bit red,
                                output logic [W2-1:0] res, output logic redOut, output int lat);
      bit seen;
      @(negedge clk);
      if (!sel) begin
         inValidA = 1'b1; sumA = s; carryA = c; modA = m; reduceA = red; outReadyA = 1'b1;
      end else begin
         inValidB = 1'b1; sumB = s; carryB = c; modB = m; reduceB = red; outReadyB = 1'b1;
      end
      @(posedge clk); #1;
      inValidA = 1'b0; sumA = ~s; carryA = ~c; modA = ~m; reduceA = ~red;
      inValidB = 1'b0; sumB = ~s; carryB = ~c; modB = ~m; reduceB = ~red;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 60) begin
         @(posedge clk); lat++; #1;
         seen = sel ? outValidB : outValidA;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL op_timeout: out_valid still 0 after %0d cycles, required 1", lat);
      end
      res    = sel ? resultB : resultA;
      redOut = sel ? reducedB : reducedA;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      inValidA = 0; reduceA = 0; sumA = '0; carryA = '0; modA = '0; outReadyA = 1'b1;
      inValidB = 0; reduceB = 0; sumB = '0; carryB = '0; modB = '0; outReadyB = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (inReadyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", inReadyA); end
      checks++;
      if (outValidA !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", outValidA); end
      checks++;
      if (resultA !== '0 || reducedA !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_result: got %h/%b want 0/0", resultA, reducedA);
      end
      checks++;
      if (inReadyB !== 1'b1 || outValidB !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_b: in_ready=%b out_valid=%b want 1/0", inReadyB, outValidB);
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_small_reduce();
      logic [W2-1:0] res; logic red; int lat;
      applyStimulus(0, 514'd5, 514'd7, 512'd11, 1'b1, res, red, lat);
      checks++;
      if (res !== 514'd1 || red !== 1'b1) begin
         errors++; $display("[TB] FAIL small_reduce: got %h/%b want 1/1", res, red);
      end
      checks++;
      if (lat != 11) begin errors++; $display("[TB] FAIL small_reduce_latency: got %0d want 11", lat); end
   endtask

   task automatic test_carry_ripple();
      logic [W2-1:0] res, s, expv; logic red; int lat;
      s    = (514'd1 << 512) - 514'd1;
      expv = 514'd1 << 512;
      applyStimulus(0, s, 514'd1, 512'd11, 1'b0, res, red, lat);
      checks++;
      if (res !== expv || red !== 1'b0) begin
         errors++; $display("[TB] FAIL carry_ripple: got %h/%b want %h/0", res, red, expv);
      end
      checks++;
      if (lat != 6) begin errors++; $display("[TB] FAIL carry_ripple_latency: got %0d want 6", lat); end
   endtask

   task automatic test_boundary();
      logic [W2-1:0] res, half, full, mMinus1; logic [WIDTH-1:0] m; logic red; int lat;
      half    = 514'd1 << 511;
      full    = 514'd1 << 512;
      m       = (512'd1 << 511) + 512'd3;
      mMinus1 = half + 514'd2;
      applyStimulus(0, half, 514'd3, m, 1'b1, res, red, lat);
      checks++;
      if (res !== '0 || red !== 1'b1) begin
         errors++; $display("[TB] FAIL boundary_eq_m: got %h/%b want 0/1", res, red);
      end
      applyStimulus(0, half, 514'd2, m, 1'b1, res, red, lat);
      checks++;
      if (res !== mMinus1 || red !== 1'b0) begin
         errors++; $display("[TB] FAIL boundary_m_minus_1: got %h/%b want %h/0", res, red, mMinus1);
      end
      applyStimulus(0, full, 514'd5, m, 1'b1, res, red, lat);
      checks++;
      if (res !== mMinus1 || red !== 1'b1) begin
         errors++; $display("[TB] FAIL boundary_2m_minus_1: got %h/%b want %h/1", res, red, mMinus1);
      end
   endtask

   task automatic test_wrap_partial();
      logic [W2-1:0] res, top, p400; logic red; int lat;
      top  = 514'd1 << 513;
      p400 = 514'd1 << 400;
      applyStimulus(0, top, top, 512'd11, 1'b0, res, red, lat);
      checks++;
      if (res !== '0 || red !== 1'b0) begin
         errors++; $display("[TB] FAIL wrap_a: got %h/%b want 0/0", res, red);
      end
      applyStimulus(0, top, top, 512'd11, 1'b1, res, red, lat);
      checks++;
      if (res !== '0 || red !== 1'b0) begin
         errors++; $display("[TB] FAIL wrap_a_reduce: got %h/%b want 0/0", res, red);
      end
      applyStimulus(1, top, top, 512'd11, 1'b0, res, red, lat);
      checks++;
      if (res !== '0 || red !== 1'b0) begin
         errors++; $display("[TB] FAIL wrap_b: got %h/%b want 0/0", res, red);
      end
      checks++;
      if (lat != 7) begin errors++; $display("[TB] FAIL wrap_b_latency: got %0d want 7", lat); end
      applyStimulus(1, p400 + 514'd5, p400 - 514'd5, 512'd1 << 400, 1'b1, res, red, lat);
      checks++;
      if (res !== p400 || red !== 1'b1) begin
         errors++; $display("[TB] FAIL partial_b_reduce: got %h/%b want %h/1", res, red, p400);
      end
      checks++;
      if (lat != 13) begin errors++; $display("[TB] FAIL partial_b_latency: got %0d want 13", lat); end
   endtask

   task automatic test_backpressure();
      logic [W2-1:0] expv;
      int waitCnt;
      expv = 514'd73;
      @(negedge clk);
      inValidA = 1'b1; sumA = 514'd100; carryA = 514'd23; modA = 512'd50; reduceA = 1'b1; outReadyA = 1'b0;
      @(posedge clk); #1;
      inValidA = 1'b0;
      waitCnt = 0;
      while (outValidA !== 1'b1 && waitCnt < 60) begin
         @(posedge clk); #1; waitCnt++;
      end
      checks++;
      if (outValidA !== 1'b1) begin
         errors++; $display("[TB] FAIL backpressure_timeout: out_valid=%b want 1", outValidA);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         inValidA = (i % 2 == 0); sumA = 514'(i + 7); carryA = 514'(i); modA = 512'd3; reduceA = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (outValidA !== 1'b1 || resultA !== expv || reducedA !== 1'b1 || inReadyA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_hold[%0d]: got v=%b r=%h red=%b rdy=%b want 1/%h/1/0",
                     i, outValidA, resultA, reducedA, inReadyA, expv);
         end
      end
      @(negedge clk);
      inValidA = 1'b0; outReadyA = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (outValidA !== 1'b0 || inReadyA !== 1'b1) begin
         errors++; $display("[TB] FAIL backpressure_release: out_valid=%b in_ready=%b want 0/1", outValidA, inReadyA);
      end
      checks++;
      if (resultA !== expv) begin
         errors++; $display("[TB] FAIL backpressure_result_kept: got %h want %h", resultA, expv);
      end
   endtask

   task automatic test_back_to_back();
      logic [W2-1:0] res; logic red; int lat;
      applyStimulus(0, 514'd20, 514'd30, 512'd7, 1'b1, res, red, lat);
      checks++;
      if (res !== 514'd43 || red !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_first: got %h/%b want 2b/1", res, red);
      end
      checks++;
      if (inReadyA !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b want 1", inReadyA); end
      applyStimulus(0, 514'd2, 514'd3, 512'd7, 1'b1, res, red, lat);
      checks++;
      if (res !== 514'd5 || red !== 1'b0 || lat != 11) begin
         errors++; $display("[TB] FAIL b2b_second: got %h/%b lat=%0d want 5/0 lat=11", res, red, lat);
      end
   endtask

   task automatic test_reset_midop();
      logic [W2-1:0] res; logic red; int lat;
      @(negedge clk);
      inValidA = 1'b1; sumA = 514'd1000; carryA = 514'd24; modA = 512'd1000; reduceA = 1'b1; outReadyA = 1'b1;
      @(posedge clk); #1;
      inValidA = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (outValidA !== 1'b0 || resultA !== '0 || inReadyA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midop_reset: out_valid=%b result=%h in_ready=%b want 0/0/1", outValidA, resultA, inReadyA);
      end
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(0, 514'd1000, 514'd24, 512'd1000, 1'b1, res, red, lat);
      checks++;
      if (res !== 514'd24 || red !== 1'b1 || lat != 11) begin
         errors++; $display("[TB] FAIL midop_fresh: got %h/%b lat=%0d want 18/1 lat=11", res, red, lat);
      end
   endtask

   task automatic test_random();
      logic [W2-1:0] s, c, x, expv, res, mExt;
      logic [WIDTH-1:0] m;
      logic red, expRed, rd;
      int lat, expLat;
      bit sel;
      for (int i = 0; i < 550; i++) begin
         sel = (i >= 500);
         s = rnd514();
         c = rnd514();
         if (i % 3 == 0) begin
            s[W2-1:WIDTH] = 2'b00;
            c[W2-1:WIDTH] = 2'b00;
         end
         mExt = rnd514();
         m = mExt[WIDTH-1:0];
         if (i % 2 == 0) m[WIDTH-1] = 1'b1;
         if (m == '0) m = 512'd1;
         rd = $urandom_range(0, 1);
         x = s + c;
         mExt = {2'b00, m};
         if (rd && x >= mExt) begin
            expv = x - mExt; expRed = 1'b1;
         end else begin
            expv = x; expRed = 1'b0;
         end
         expLat = (rd ? 2 : 1) * (sel ? 6 : 5) + 1;
         applyStimulus(sel, s, c, m, rd, res, red, lat);
         checks++;
         if (res !== expv || red !== expRed) begin
            errors++; $display("[TB] FAIL random[%0d]: got %h/%b want %h/%b", i, res, red, expv, expRed);
         end
         checks++;
         if (lat != expLat) begin
            errors++; $display("[TB] FAIL random_latency[%0d]: got %0d want %0d", i, lat, expLat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_small_reduce();
      test_carry_ripple();
      test_boundary();
      test_wrap_partial();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
